// File: rtl/mux_out_packer_if.sv
// Bus between the mux output packer and its neighbours: symbol input, clear, pop and FIFO status.
// Optional rd_parity signal is present when PACKER_PARITY_EN is defined.
interface mux_out_packer_if #(
  parameter int SYM_W         = 2,
  parameter int SYMS_PER_WORD = 4,
  parameter int DEPTH         = 4
);
  localparam int W  = SYM_W * SYMS_PER_WORD;
  localparam int FW = $clog2(DEPTH + 1);

  // valid_in qualifies data_in for one edge with no backpressure; pop consumes
  // the head only when empty=0 and is silently ignored otherwise.
  logic [SYM_W-1:0] data_in;
  logic             valid_in;
  logic             sync_clr;
  logic             pop;
  logic [W-1:0]     rd_data;
  logic             empty;
  logic             full;
  logic [FW-1:0]    fill;
  logic             overflow;
`ifdef PACKER_PARITY_EN
  logic             rd_parity;
`endif

  modport master (
    output data_in, valid_in, sync_clr, pop,
    input  rd_data, empty, full, fill, overflow
`ifdef PACKER_PARITY_EN
    , input rd_parity
`endif
  );

  modport slave (
    input  data_in, valid_in, sync_clr, pop,
    output rd_data, empty, full, fill, overflow
`ifdef PACKER_PARITY_EN
    , output rd_parity
`endif
  );
endinterface

// File: rtl/mux_out_packer.sv
// Packs 2-bit mux symbols MSB-first into words and buffers them in a FWFT FIFO.
// Define PACKER_PARITY_EN to store a parity bit per word and expose rd_parity.
module mux_out_packer #(
  parameter int SYM_W         = 2,
  parameter int SYMS_PER_WORD = 4,
  parameter int DEPTH         = 4
) (
  input  logic               clk,
  input  logic               reset_L,
  mux_out_packer_if.slave    bus
);
  localparam int W  = SYM_W * SYMS_PER_WORD;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(DEPTH + 1);
  localparam int CW = (SYMS_PER_WORD > 1) ? $clog2(SYMS_PER_WORD) : 1;
`ifdef PACKER_PARITY_EN
  localparam int EW = W + 1;
`else
  localparam int EW = W;
`endif

  localparam logic [CW-1:0] LAST_SYM = CW'(SYMS_PER_WORD - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  logic [W-1:0]  acc;
  logic [CW-1:0] sym_cnt;
  logic [W-1:0]  word_next;
  logic [EW-1:0] entry_next;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [FW-1:0] fill_q;
  logic          overflow_q;

  logic take_sym;
  logic push;
  logic do_pop;
  logic accept;
  logic drop;

  // Merge the current symbol into its slot so a completing word includes it.
  always_comb begin
    word_next = acc;
    for (int k = 0; k < SYMS_PER_WORD; k++) begin
      if (sym_cnt == CW'(k)) begin
        word_next[W-1-k*SYM_W -: SYM_W] = bus.data_in;
      end
    end
  end

`ifdef PACKER_PARITY_EN
  assign entry_next = {^word_next, word_next};
`else
  assign entry_next = word_next;
`endif

  assign take_sym = bus.valid_in && !bus.sync_clr;
  assign push     = take_sym && (sym_cnt == LAST_SYM);
  assign do_pop   = bus.pop && (fill_q != '0);
  // A pop on a full FIFO frees the slot the same edge's push needs.
  assign accept   = push && ((fill_q != FILL_MAX) || do_pop);
  assign drop     = push && !accept;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      acc     <= '0;
      sym_cnt <= '0;
    end else if (bus.sync_clr || push) begin
      acc     <= '0;
      sym_cnt <= '0;
    end else if (take_sym) begin
      acc     <= word_next;
      sym_cnt <= sym_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      case ({accept, do_pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible while fill is non-zero.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= entry_next;
  end

  assign bus.empty    = (fill_q == '0);
  assign bus.full     = (fill_q == FILL_MAX);
  assign bus.fill     = fill_q;
  assign bus.overflow = overflow_q;
  assign bus.rd_data  = bus.empty ? '0 : mem[rd_ptr][W-1:0];
`ifdef PACKER_PARITY_EN
  assign bus.rd_parity = bus.empty ? 1'b0 : mem[rd_ptr][W];
`endif
endmodule

// File: tb/tb_mux_out_packer.sv
// Directed plus randomized bench for mux_out_packer against a queue-based reference model.
// Honours PACKER_PARITY_EN when defined for the build.
module tb_mux_out_packer;
  localparam int SYM_W = 2;
  localparam int SPW   = 4;
  localparam int DEPTH = 4;
  localparam int W     = SYM_W * SPW;

  logic clk;
  logic reset_L;
  int   checks;
  int   errors;

  mux_out_packer_if #(.SYM_W(SYM_W), .SYMS_PER_WORD(SPW), .DEPTH(DEPTH)) bus ();

  mux_out_packer #(.SYM_W(SYM_W), .SYMS_PER_WORD(SPW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus.slave)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0]     exp_q[$];
  logic [SYM_W-1:0] sym_q[$];
  bit               m_ovf;

  function automatic void model_reset();
    exp_q.delete();
    sym_q.delete();
    m_ovf = 1'b0;
  endfunction

  function automatic void model_edge(input logic vi, input logic [SYM_W-1:0] d,
                                     input logic sc, input logic p);
    int           held;
    bit           popped;
    bit           have_word;
    logic [W-1:0] word;
    held      = exp_q.size();
    popped    = p && (held > 0);
    have_word = 1'b0;
    word      = '0;
    if (sc) begin
      sym_q.delete();
    end else if (vi) begin
      sym_q.push_back(d);
      if (sym_q.size() == SPW) begin
        foreach (sym_q[i]) word = (word << SYM_W) | W'(sym_q[i]);
        have_word = 1'b1;
        sym_q.delete();
      end
    end
    if (popped) void'(exp_q.pop_front());
    if (have_word) begin
      if (held == DEPTH && !popped) m_ovf = 1'b1;
      else exp_q.push_back(word);
    end
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    check({tag, ".rd_data"},  32'(bus.rd_data),  32'(head));
    check({tag, ".empty"},    32'(bus.empty),    32'(exp_q.size() == 0));
    check({tag, ".full"},     32'(bus.full),     32'(exp_q.size() == DEPTH));
    check({tag, ".fill"},     32'(bus.fill),     32'(exp_q.size()));
    check({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
`ifdef PACKER_PARITY_EN
    check({tag, ".rd_parity"}, 32'(bus.rd_parity), 32'(^head));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input string tag, input logic vi, input logic [SYM_W-1:0] d,
                      input logic sc, input logic p);
    @(negedge clk);
    bus.valid_in = vi;
    bus.data_in  = d;
    bus.sync_clr = sc;
    bus.pop      = p;
    @(posedge clk);
    model_edge(vi, d, sc, p);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    bus.sync_clr = 1'b0;
    bus.pop      = 1'b0;
  endtask

  // Asynchronous reset asserted away from any edge, outputs checked immediately.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    idle_inputs();
    reset_L = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic send_word(input string tag, input logic [W-1:0] w, input logic pop_last);
    for (int k = 0; k < SPW; k++) begin
      step(tag, 1'b1, w[W-1-k*SYM_W -: SYM_W], 1'b0, pop_last && (k == SPW - 1));
    end
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] t4_words [5];
  logic [W-1:0] t4_last;

  initial begin
    checks  = 0;
    errors  = 0;
    reset_L = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    check_all("por");
    reset_L = 1'b1;

    // Reset mid-word and with a word held
    send_word("pre", 8'h3C, 1'b0);
    step("pre", 1'b1, 2'b10, 1'b0, 1'b0);
    do_reset("rst_mid");
    check("rst_mid.rd_data_const", 32'(bus.rd_data), 32'h0);

    // Consecutive symbols 11,10,01,00
    step("t2", 1'b1, 2'b11, 1'b0, 1'b0);
    step("t2", 1'b1, 2'b10, 1'b0, 1'b0);
    step("t2", 1'b1, 2'b01, 1'b0, 1'b0);
    check("t2.still_empty", 32'(bus.empty), 32'h1);
    step("t2", 1'b1, 2'b00, 1'b0, 1'b0);
    check("t2.word", 32'(bus.rd_data), 32'hE4);
    check("t2.fill", 32'(bus.fill), 32'h1);
    step("t2", 1'b0, 2'b00, 1'b0, 1'b1);

    // Same symbols with gap cycles carrying 11
    step("t3", 1'b1, 2'b11, 1'b0, 1'b0);
    step("t3", 1'b0, 2'b11, 1'b0, 1'b0);
    step("t3", 1'b1, 2'b10, 1'b0, 1'b0);
    step("t3", 1'b0, 2'b11, 1'b0, 1'b0);
    step("t3", 1'b0, 2'b11, 1'b0, 1'b0);
    step("t3", 1'b1, 2'b01, 1'b0, 1'b0);
    step("t3", 1'b0, 2'b11, 1'b0, 1'b0);
    step("t3", 1'b1, 2'b00, 1'b0, 1'b0);
    check("t3.word", 32'(bus.rd_data), 32'hE4);
    step("t3", 1'b0, 2'b00, 1'b0, 1'b1);

    // Overflow: five words, no pop, then drain
    t4_words = '{8'h00, 8'h55, 8'hAA, 8'hFF, 8'h1B};
    for (int i = 0; i < 5; i++) send_word("t4", t4_words[i], 1'b0);
    check("t4.full", 32'(bus.full), 32'h1);
    check("t4.fill", 32'(bus.fill), 32'h4);
    check("t4.overflow", 32'(bus.overflow), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("t4.drain", 32'(bus.rd_data), 32'(t4_words[i]));
      step("t4", 1'b0, 2'b00, 1'b0, 1'b1);
    end
    check("t4.empty", 32'(bus.empty), 32'h1);
    check("t4.ovf_sticky", 32'(bus.overflow), 32'h1);

    // Push and pop on the same edge while full
    do_reset("t5_rst");
    for (int i = 0; i < 4; i++) send_word("t5", 8'(8'h11 * (i + 1)), 1'b0);
    send_word("t5", 8'hC3, 1'b1);
    check("t5.fill", 32'(bus.fill), 32'h4);
    check("t5.overflow", 32'(bus.overflow), 32'h0);
    t4_last = '0;
    for (int i = 0; i < 4; i++) begin
      t4_last = bus.rd_data;
      step("t5", 1'b0, 2'b00, 1'b0, 1'b1);
    end
    check("t5.last_out", 32'(t4_last), 32'hC3);

    // Push and pop on the same edge while empty
    send_word("t5e", 8'h96, 1'b1);
    check("t5e.fill", 32'(bus.fill), 32'h1);
    step("t5e", 1'b0, 2'b00, 1'b0, 1'b1);

    // sync_clr discards a partial word, beating a simultaneous valid
    step("t6", 1'b1, 2'b11, 1'b0, 1'b0);
    step("t6", 1'b1, 2'b11, 1'b0, 1'b0);
    step("t6", 1'b1, 2'b10, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("t6", 1'b1, 2'b01, 1'b0, 1'b0);
    check("t6.word", 32'(bus.rd_data), 32'h55);
    check("t6.fill", 32'(bus.fill), 32'h1);
`ifdef PACKER_PARITY_EN
    check("t6.parity", 32'(bus.rd_parity), 32'h0);
`endif

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step("rand",
           1'($urandom_range(0, 9) < 7),
           2'($urandom_range(0, 3)),
           1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 9) < 3));
      if (n == 200) do_reset("rand_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
